// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU op selects, operand-1 selects and the
// decoded bundle that the decode stage registers.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'b00,
        OP1_PC   = 2'b01,
        OP1_ZERO = 2'b10
    } op1_sel_e;

    typedef struct packed {
        logic [2:0]  opsel;
        logic        sub;
        logic        is_unsigned;
        logic        arith;
        op1_sel_e    op1_sel;
        logic        op2_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  funct3;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate extraction; format chosen from the opcode.
// Shift-immediates yield the zero-extended shamt so funct7 never leaks into it.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    logic [2:0] funct3;
    assign funct3 = inst[14:12];

    always_comb begin
        imm = 32'd0;
        case (inst[6:0])
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm = {27'd0, inst[24:20]};
                end else begin
                    imm = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:          imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:         imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_JAL:            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'd0};
            default:            imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage between fetch and execute (valid/ready + flush).
// Define RV32I_DECODE_ILLEGAL_EN to enable illegal-encoding detection.
module rv32i_decode_stage
    import rv32i_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [2:0]  o_opsel,
    output logic        o_sub,
    output logic        o_unsigned,
    output logic        o_arith,
    output logic [1:0]  o_op1_sel,
    output logic        o_op2_imm,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_rd_wen,
    output logic        o_branch,
    output logic        o_jal,
    output logic        o_jalr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [2:0]  o_funct3,
    output logic        o_illegal
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the bundle is held stable while o_valid & !i_ready, and flush
    // drops both the held and the incoming instruction.

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        rd_write;
    logic        load;
    dec_t        dec;
    dec_t        q;
    logic [31:0] pc_q;
    logic        valid_q;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];

    rv32i_imm_gen u_imm_gen (
        .inst (i_inst),
        .imm  (imm)
    );

`ifdef RV32I_DECODE_ILLEGAL_EN
    logic [6:0] funct7;
    logic       illegal;
    assign funct7 = i_inst[31:25];

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OPC_OP: illegal = !((funct7 == 7'b0000000) ||
                                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            OPC_OP_IMM: begin
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                end
            end
            OPC_BRANCH: illegal = (funct3 == 3'b010 || funct3 == 3'b011);
            OPC_LOAD:   illegal = (funct3 == 3'b011 || funct3[2:1] == 2'b11);
            OPC_STORE:  illegal = (funct3 > 3'b010);
            OPC_JALR:   illegal = (funct3 != 3'b000);
            OPC_LUI, OPC_AUIPC, OPC_JAL: illegal = 1'b0;
            default:    illegal = 1'b1;
        endcase
    end
`endif

    always_comb begin
        dec        = '0;
        dec.imm    = imm;
        dec.rs1    = i_inst[19:15];
        dec.rs2    = i_inst[24:20];
        dec.rd     = i_inst[11:7];
        dec.funct3 = funct3;
        rd_write   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.opsel       = funct3;
                dec.sub         = (funct3 == 3'b000) && i_inst[30];
                dec.arith       = (funct3 == 3'b101) && i_inst[30];
                dec.is_unsigned = (funct3 == 3'b011);
                rd_write        = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.opsel       = funct3;
                dec.arith       = (funct3 == 3'b101) && i_inst[30];
                dec.is_unsigned = (funct3 == 3'b011);
                dec.op2_imm     = 1'b1;
                rd_write        = 1'b1;
            end
            OPC_BRANCH: begin
                dec.opsel       = ALU_SLT;
                dec.is_unsigned = funct3[1];
                dec.branch      = 1'b1;
            end
            OPC_LOAD: begin
                dec.op2_imm = 1'b1;
                dec.mem_rd  = 1'b1;
                rd_write    = 1'b1;
            end
            OPC_STORE: begin
                dec.op2_imm = 1'b1;
                dec.mem_wr  = 1'b1;
            end
            OPC_JAL: begin
                dec.op1_sel = OP1_PC;
                dec.op2_imm = 1'b1;
                dec.jal     = 1'b1;
                rd_write    = 1'b1;
            end
            OPC_JALR: begin
                dec.op2_imm = 1'b1;
                dec.jalr    = 1'b1;
                rd_write    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op1_sel = OP1_PC;
                dec.op2_imm = 1'b1;
                rd_write    = 1'b1;
            end
            OPC_LUI: begin
                dec.op1_sel = OP1_ZERO;
                dec.op2_imm = 1'b1;
                rd_write    = 1'b1;
            end
            default: ;
        endcase
`ifdef RV32I_DECODE_ILLEGAL_EN
        dec.illegal = illegal;
        if (illegal) begin
            rd_write   = 1'b0;
            dec.mem_rd = 1'b0;
            dec.mem_wr = 1'b0;
            dec.branch = 1'b0;
            dec.jal    = 1'b0;
            dec.jalr   = 1'b0;
        end
`endif
        dec.rd_wen = rd_write && (dec.rd != 5'd0);
    end

    assign o_ready = !valid_q || i_ready;
    assign load    = i_valid && o_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Payload only moves on load so a flushed or drained bundle keeps its data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q    <= '0;
            pc_q <= 32'd0;
        end else if (load) begin
            q    <= dec;
            pc_q <= i_pc;
        end
    end

    assign o_valid    = valid_q;
    assign o_pc       = pc_q;
    assign o_opsel    = q.opsel;
    assign o_sub      = q.sub;
    assign o_unsigned = q.is_unsigned;
    assign o_arith    = q.arith;
    assign o_op1_sel  = q.op1_sel;
    assign o_op2_imm  = q.op2_imm;
    assign o_imm      = q.imm;
    assign o_rs1      = q.rs1;
    assign o_rs2      = q.rs2;
    assign o_rd       = q.rd;
    assign o_rd_wen   = q.rd_wen;
    assign o_branch   = q.branch;
    assign o_jal      = q.jal;
    assign o_jalr     = q.jalr;
    assign o_mem_rd   = q.mem_rd;
    assign o_mem_wr   = q.mem_wr;
    assign o_funct3   = q.funct3;
    assign o_illegal  = q.illegal;

endmodule

// File: doc/rv32i_decode_stage.md
# rv32i_decode_stage

Registered instruction decode stage that converts a fetched RV32I instruction word into the ALU control set (opsel/sub/unsigned/arith), operand selects, immediate, register indices and control flags. It sits between fetch and execute. It is the producing end of the ALU control interface: it generates what the ALU consumes. It is a single pipeline register with valid/ready handshakes on both sides, plus flush.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_flush  input  1  discard held and incoming instruction (branch redirect).
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  stage can accept; combinational = !o_valid | i_ready.
- i_inst  input  32  instruction word.
- i_pc  input  32  instruction address.
- o_valid  output  1  decoded bundle valid.
- i_ready  input  1  execute accepts bundle.
- o_pc  output  32  registered copy of i_pc.
- o_opsel  output  3  ALU major op (000 add/sub, 001 sll, 010/011 slt, 100 xor, 101 sr, 110 or, 111 and).
- o_sub, o_unsigned, o_arith  output  1 each  ALU modifiers.
- o_op1_sel  output  2  00 rs1, 01 pc, 10 zero.
- o_op2_imm  output  1  1 = immediate, 0 = rs2.
- o_imm  output  32  sign-extended immediate.
- o_rs1, o_rs2, o_rd  output  5 each  register indices.
- o_rd_wen  output  1  writes rd (forced 0 when rd = x0).
- o_branch, o_jal, o_jalr, o_mem_rd, o_mem_wr  output  1 each  class flags.
- o_funct3  output  3  raw funct3 for branch condition and load/store size.
- o_illegal  output  1  unsupported encoding (see Configuration).

## Operation
- Load when i_valid & o_ready & !i_flush: all outputs are registered from the decode of i_inst; o_valid <= 1.
- When o_valid & i_ready and no new load: o_valid <= 0. Payload holds its last value.
- Stall (o_valid & !i_ready): every output holds; o_ready = 0.
- Flush: o_valid <= 0 regardless of the other inputs; a simultaneous input is consumed and dropped. Flush has priority over load.
- Decode rules:
  - OP/OP-IMM: opsel = funct3.
  - sub = OP & funct3==000 & funct7[5].
  - arith = funct3==101 & funct7[5].
  - unsigned = funct3==011.
  - op2_imm = OP-IMM.
- BRANCH: opsel 010, unsigned = funct3[1], op2_imm 0, rd_wen 0, branch 1.
- LOAD/STORE/JAL/JALR/AUIPC: opsel 000, sub 0.
  - AUIPC and JAL use op1_sel 01.
  - LUI uses op1_sel 10, op2_imm 1.
- Immediates: I, S, B, U, J formats per RV32I, sign bit i_inst[31]; U format is {inst[31:12], 12'b0}.
- Payload outputs are 0 during reset; after reset they change only on load.

## Timing
- Latency 1 cycle from accepted input to o_valid.
- Throughput 1 instruction per cycle while i_ready = 1.
- Reset value: o_valid = 0 and all registered outputs = 0.
- o_ready is a combinational path from i_ready.
- Reset asserted mid-stall: o_valid clears immediately (asynchronous); the bundle is lost.

## Configuration
- RV32I_DECODE_ILLEGAL_EN defined:
  - o_illegal = 1 for an unknown opcode, a bad funct7 on OP/shift-immediate, or an invalid funct3 on BRANCH/LOAD/STORE/JALR.
  - When o_illegal = 1: o_rd_wen, o_mem_rd, o_mem_wr, o_branch, o_jal and o_jalr are forced 0.
- Not defined: o_illegal is tied 0, with no check logic, and unknown opcodes decode as a no-write add.

## Structure
- Shared package rv32i_pkg holds:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - ALU opsel constants;
  - op1_sel encodings.
- Sub-module rv32i_imm_gen: purely combinational immediate extraction, instantiated ahead of the pipeline register.

## Test plan
- ADD x3,x1,x2 (0x002081B3), i_ready = 1 → next cycle o_valid 1, opsel 000, sub 0, rs1 1, rs2 2, rd 3, op2_imm 0, rd_wen 1.
- SUB x5,x6,x7 (0x407302B3) → sub 1, opsel 000. SRAI x1,x2,3 (0x40315093) → opsel 101, arith 1, op2_imm 1, imm 0x00000003.
- BLTU x1,x2,-8 (0xFE20ECE3) → opsel 010, unsigned 1, branch 1, rd_wen 0, imm 0xFFFFFFF8, funct3 110.
- Load ADD, then i_ready = 0 for 3 cycles while i_valid = 1 → o_ready 0 and outputs unchanged for 3 cycles; on release the next instruction appears one cycle later.
- i_flush with i_valid in the same cycle → o_valid 0 next cycle. Assert i_rst_n = 0 mid-stall → o_valid 0 without waiting for a clock edge.
- 0xFFFFFFFF with RV32I_DECODE_ILLEGAL_EN → o_illegal 1, rd_wen 0, mem_wr 0. Without the macro → o_illegal 0.
